alu_operand_stage: RTL
======================

# alu_operand_stage

Registered operand-select stage between register read and the ALU. It extends the earlier single-operand register/immediate mux to two operands. It adds sign or zero extension of a parametrised immediate, optional EX/MEM result forwarding, and a one-deep valid/ready pipeline register with flush. It also counts consecutive back-pressure cycles for the hazard/debug logic.

## Interface
- DATA_W, 16, register/ALU operand width
- IMM_W, 4, immediate field width; legal range 1..DATA_W
- STALL_CNT_W, 4, width of the saturating stall counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream operands valid
- in_ready  output  1  stage can accept this cycle
- rs1_data  input  DATA_W  register operand A
- rs2_data  input  DATA_W  register operand B
- imm  input  IMM_W  immediate field
- imm_signed  input  1  1 = sign-extend imm, 0 = zero-extend
- b_src  input  1  1 = operand B from extended imm, 0 = from B source select
- fwd_a_sel  input  2  operand A source: 00 reg, 01 EX, 10 MEM, 11 reg
- fwd_b_sel  input  2  operand B source, same encoding
- ex_result  input  DATA_W  EX-stage result for forwarding
- mem_result  input  DATA_W  MEM-stage result for forwarding
- flush  input  1  kill the held/incoming operation
- out_valid  output  1  op_a/op_b valid
- out_ready  input  1  ALU accepts this cycle
- op_a  output  DATA_W  registered operand A
- op_b  output  DATA_W  registered operand B
- stall_cnt  output  STALL_CNT_W  consecutive cycles with out_valid && !out_ready

## Operation
- Extension: IMM_W < DATA_W replicates imm[IMM_W-1] when imm_signed=1, otherwise pads with zeros. IMM_W == DATA_W passes imm through unchanged.
- Operand A source: fwd_a_sel selects rs1_data, ex_result or mem_result. Code 11 selects rs1_data.
- Operand B source: b_src=1 selects the extended imm and ignores fwd_b_sel. Otherwise fwd_b_sel selects as for operand A.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Load: when in_valid && in_ready && !flush, the selected A/B values are written to op_a/op_b and out_valid is set to 1.
- Drain: when out_ready && out_valid and no load occurs, out_valid clears. op_a/op_b hold their last values.
- Hold: when out_valid && !out_ready, op_a/op_b are held stable. Upstream sees in_ready=0.
- Flush: takes priority over load and hold. The next edge sets out_valid=0 and discards any in_valid beat in that cycle. op_a/op_b are unchanged.
- stall_cnt:
  - Increments each edge with out_valid && !out_ready.
  - Saturates at all-ones.
  - Clears to 0 on any edge where that condition is false, including flush.

## Timing
- Latency: 1 cycle from an accepted beat to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Reset (asynchronous, immediate): out_valid=0, op_a=0, op_b=0, stall_cnt=0. in_ready reads 1 during and after reset.
- Reset mid-hold drops the held beat. There is no replay.
- Simultaneous drain and load produces back-to-back beats, with out_valid staying 1.
- Forwarded values are sampled on the accepting edge only. Later changes to ex_result/mem_result do not alter held operands.

## Configuration
- ALU_OPERAND_FWD_EN defined: ex_result/mem_result forwarding is active as described.
- ALU_OPERAND_FWD_EN undefined:
  - fwd_a_sel/fwd_b_sel are ignored; A always takes rs1_data, and B takes rs2_data when b_src=0.
  - ex_result/mem_result remain as ports but are unused.
- All other behaviour is identical.

## Structure
- Shared package alu_operand_pkg holds:
  - 2-bit source-select constants SRC_REG=2'b00, SRC_EX=2'b01, SRC_MEM=2'b10.
  - A default DATA_W constant.
- One sub-module: imm_extend, a combinational IMM_W to DATA_W sign/zero extender with an imm_signed control input. Instantiate it once.

## Test plan
- DATA_W=16, IMM_W=4, b_src=1, imm=4'b1010:
  - imm_signed=1 -> op_b=16'hFFFA one cycle after acceptance.
  - imm_signed=0 -> op_b=16'h000A.
- fwd_a_sel=01, ex_result=16'h1234, rs1_data=16'h0001, with ALU_OPERAND_FWD_EN defined -> op_a=16'h1234.
  - Same stimulus with the macro undefined -> op_a=16'h0001.
- Hold out_ready=0 for 20 cycles with STALL_CNT_W=4:
  - in_ready=0, op_a/op_b stable, stall_cnt saturates at 4'hF.
  - Raise out_ready -> stall_cnt=0 on the next edge.
- Stream 8 beats with in_valid=1, out_ready=1 -> 8 consecutive out_valid cycles, each op_a equal to the input from the previous cycle.
- flush=1 coincident with in_valid=1 while out_valid=1 -> next cycle out_valid=0, and the incoming beat never appears.
- Assert rst asynchronously between clock edges while out_valid=1 -> out_valid, op_a, op_b, stall_cnt all 0 before the next edge.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// Shared constants for the ALU operand-select stage: forwarding source codes
// and the default operand width.
package alu_operand_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_EX  = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;

endpackage

// File: rtl/imm_extend.sv
// Combinational IMM_W -> DATA_W immediate extender, sign or zero fill
// selected by imm_signed.
module imm_extend #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 4
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_signed,
    output logic [DATA_W-1:0] imm_ext
);

    if (IMM_W == DATA_W) begin : g_pass
        logic unused_imm_signed;
        assign unused_imm_signed = imm_signed;
        assign imm_ext = imm;
    end else begin : g_ext
        logic fill;
        assign fill    = imm_signed & imm[IMM_W-1];
        assign imm_ext = {{(DATA_W - IMM_W){fill}}, imm};
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered two-operand select stage with immediate extension, a one-deep
// valid/ready register with flush, and a saturating stall counter.
// EX/MEM forwarding is enabled by defining ALU_OPERAND_FWD_EN.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned IMM_W       = 4,
    parameter int unsigned STALL_CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      rs1_data,
    input  logic [DATA_W-1:0]      rs2_data,
    input  logic [IMM_W-1:0]       imm,
    input  logic                   imm_signed,
    input  logic                   b_src,
    input  logic [1:0]             fwd_a_sel,
    input  logic [1:0]             fwd_b_sel,
    input  logic [DATA_W-1:0]      ex_result,
    input  logic [DATA_W-1:0]      mem_result,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      op_a,
    output logic [DATA_W-1:0]      op_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [DATA_W-1:0]      imm_ext;
    logic [DATA_W-1:0]      a_sel, b_reg_sel, b_sel;
    logic [DATA_W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic                   out_valid_q, out_valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load, stalled;

    imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extend (
        .imm        (imm),
        .imm_signed (imm_signed),
        .imm_ext    (imm_ext)
    );

`ifdef ALU_OPERAND_FWD_EN
    always_comb begin
        a_sel = rs1_data;
        case (fwd_a_sel)
            SRC_EX:  a_sel = ex_result;
            SRC_MEM: a_sel = mem_result;
            default: a_sel = rs1_data;
        endcase
        b_reg_sel = rs2_data;
        case (fwd_b_sel)
            SRC_EX:  b_reg_sel = ex_result;
            SRC_MEM: b_reg_sel = mem_result;
            default: b_reg_sel = rs2_data;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, ex_result, mem_result};
    assign a_sel      = rs1_data;
    assign b_reg_sel  = rs2_data;
`endif

    assign b_sel    = b_src ? imm_ext : b_reg_sel;
    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign stalled  = out_valid_q && !out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        // Flush wins over both load and hold; operands are left as they were.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            op_a_d      = a_sel;
            op_b_d      = b_sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        stall_cnt_d = '0;
        if (stalled) begin
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule
